// File: rtl/word32_8bits_arbiter_if.sv
// Handshake and byte-lane bundle between two 32-bit word requesters and the
// shared 8-bit serializer lane.
interface word32_8bits_arbiter_if;
  logic        valid_in0;
  logic [31:0] Data_in0;
  logic        ready_out0;
  logic        valid_in1;
  logic [31:0] Data_in1;
  logic        ready_out1;
  logic        valid_out;
  logic [7:0]  Data_out;
  logic        src_out;
  logic        busy;

  // Arbiter side.
  modport slave (
    input  valid_in0, Data_in0, valid_in1, Data_in1,
    output ready_out0, ready_out1, valid_out, Data_out, src_out, busy
  );

  // Requester / observer side.
  modport master (
    output valid_in0, Data_in0, valid_in1, Data_in1,
    input  ready_out0, ready_out1, valid_out, Data_out, src_out, busy
  );
endinterface

// File: rtl/word32_8bits_arbiter.sv
// Two-requester round-robin arbiter feeding one 32-to-8 serializer lane.
// Words go out MSB byte first, back-to-back words with no idle gap.
module word32_8bits_arbiter #(
  parameter bit PRIORITY_INIT = 1'b0
) (
  input  logic                          clk_4f,
  input  logic                          reset,
  word32_8bits_arbiter_if.slave         bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        pref_q, pref_d;
  logic [23:0] shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        src_q, src_d;

  logic        load_slot;
  logic        gnt_valid;
  logic        gnt_idx;
  logic [31:0] word_sel;

  // The last byte of a word doubles as the load slot so words chain without a bubble.
  assign load_slot = (state_q == IDLE) || (cnt_q == 2'd3);
  assign gnt_valid = load_slot && (bus.valid_in0 || bus.valid_in1);
  assign gnt_idx   = (bus.valid_in0 && bus.valid_in1) ? pref_q : bus.valid_in1;
  assign word_sel  = gnt_idx ? bus.Data_in1 : bus.Data_in0;

  assign bus.ready_out0 = gnt_valid && !gnt_idx && reset;
  assign bus.ready_out1 = gnt_valid &&  gnt_idx && reset;

  assign bus.valid_out = valid_q;
  assign bus.Data_out  = data_q;
  assign bus.src_out   = src_q;
  assign bus.busy      = (state_q == SEND);

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path
    // through this block leaves one unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    pref_d  = pref_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    src_d   = src_q;

    if (gnt_valid) begin
      shift_d = word_sel[23:0];
      data_d  = word_sel[31:24];
      valid_d = 1'b1;
      src_d   = gnt_idx;
      cnt_d   = 2'd0;
      state_d = SEND;
      pref_d  = ~gnt_idx;
    end else if (state_q == SEND) begin
      if (cnt_q != 2'd3) begin
        cnt_d   = cnt_q + 2'd1;
        data_d  = shift_q[23:16];
        shift_d = {shift_q[15:0], 8'h00};
      end else begin
        state_d = IDLE;
        cnt_d   = 2'd0;
        valid_d = 1'b0;
        data_d  = 8'h00;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      pref_q  <= PRIORITY_INIT;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pref_q  <= pref_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      src_q   <= src_d;
    end
  end

  // NOTE: the shift register is pure datapath and is never observed while
  // valid_out is low, so it is deliberately left out of reset.
  always_ff @(posedge clk_4f) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_word32_8bits_arbiter.sv
// Directed scenario bench for word32_8bits_arbiter: reset, single word, tie,
// fairness, idle gap, reset mid-word and held request during a word.
module tb_word32_8bits_arbiter;

  logic clk_4f = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;

  word32_8bits_arbiter_if bus ();

  word32_8bits_arbiter #(.PRIORITY_INIT(1'b0)) dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_4f = ~clk_4f;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk_4f);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    return 8'(w >> (24 - 8 * i));
  endfunction

  function automatic logic [31:0] fair_word(input int req, input int j);
    return (req == 0) ? 32'h10203040 + 32'h01010101 * j : 32'h80706050 + 32'h01010101 * j;
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    bus.valid_in0 = 1'b0;
    bus.valid_in1 = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.valid_in0 = 1'b1;
    bus.Data_in0  = 32'h12345678;
    bus.valid_in1 = 1'b1;
    bus.Data_in1  = 32'h87654321;
    step();
    step();
    @(negedge clk_4f);
    n_total++;
    if ({bus.ready_out0, bus.ready_out1} !== 2'b00) $display("FAIL reset_ready: got %b expected 00", {bus.ready_out0, bus.ready_out1});
    else n_pass++;
    n_total++;
    if ({bus.valid_out, bus.Data_out, bus.src_out, bus.busy} !== 11'h000)
      $display("FAIL reset_outputs: got v=%b d=%h s=%b b=%b expected all zero", bus.valid_out, bus.Data_out, bus.src_out, bus.busy);
    else n_pass++;
    step();
    bus.valid_in0 = 1'b0;
    bus.valid_in1 = 1'b0;
    reset = 1'b1;
    @(negedge clk_4f);
    n_total++;
    if ({bus.valid_out, bus.busy} !== 2'b00) $display("FAIL reset_release: got v=%b b=%b expected 0 0", bus.valid_out, bus.busy);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [31:0] w = 32'hFFAAFFBB;
    step();
    bus.valid_in0 = 1'b1;
    bus.Data_in0  = w;
    @(negedge clk_4f);
    n_total++;
    if ({bus.ready_out0, bus.ready_out1, bus.busy} !== 3'b100) $display("FAIL single_ready: got r0r1b=%b expected 100", {bus.ready_out0, bus.ready_out1, bus.busy});
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) bus.valid_in0 = 1'b0;
      @(negedge clk_4f);
      n_total++;
      if ({bus.valid_out, bus.src_out, bus.Data_out, bus.busy, bus.ready_out0} !== {1'b1, 1'b0, byte_of(w, i), 1'b1, 1'b0})
        $display("FAIL single_byte%0d: got v=%b s=%b d=%h b=%b r0=%b expected v=1 s=0 d=%h b=1 r0=0", i, bus.valid_out, bus.src_out, bus.Data_out, bus.busy, bus.ready_out0, byte_of(w, i));
      else n_pass++;
    end
    step();
    @(negedge clk_4f);
    n_total++;
    if ({bus.valid_out, bus.Data_out, bus.busy} !== 10'h000) $display("FAIL single_end: got v=%b d=%h b=%b expected 0 00 0", bus.valid_out, bus.Data_out, bus.busy);
    else n_pass++;
  endtask

  task automatic test_tie(input logic [31:0] w0, input logic [31:0] w1, input string tag);
    step();
    bus.valid_in0 = 1'b1;
    bus.Data_in0  = w0;
    bus.valid_in1 = 1'b1;
    bus.Data_in1  = w1;
    @(negedge clk_4f);
    n_total++;
    if ({bus.ready_out0, bus.ready_out1} !== 2'b10) $display("FAIL %s_first_grant: got r0r1=%b expected 10", tag, {bus.ready_out0, bus.ready_out1});
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] eb;
      eb = (i < 4) ? byte_of(w0, i) : byte_of(w1, i - 4);
      step();
      if (i == 0) bus.valid_in0 = 1'b0;
      if (i == 4) bus.valid_in1 = 1'b0;
      @(negedge clk_4f);
      n_total++;
      if ({bus.valid_out, bus.src_out, bus.Data_out} !== {1'b1, (i >= 4), eb})
        $display("FAIL %s_byte%0d: got v=%b s=%b d=%h expected v=1 s=%0d d=%h", tag, i, bus.valid_out, bus.src_out, bus.Data_out, (i >= 4), eb);
      else n_pass++;
      n_total++;
      if (bus.ready_out1 !== (i == 3)) $display("FAIL %s_ready1_%0d: got %b expected %b", tag, i, bus.ready_out1, (i == 3));
      else n_pass++;
    end
    step();
    @(negedge clk_4f);
    n_total++;
    if ({bus.valid_out, bus.Data_out} !== 9'h000) $display("FAIL %s_end: got v=%b d=%h expected 0 00", tag, bus.valid_out, bus.Data_out);
    else n_pass++;
  endtask

  task automatic test_fairness();
    int j0 = 0;
    int j1 = 0;
    step();
    bus.valid_in0 = 1'b1;
    bus.Data_in0  = fair_word(0, 0);
    bus.valid_in1 = 1'b1;
    bus.Data_in1  = fair_word(1, 0);
    @(negedge clk_4f);
    n_total++;
    if ({bus.ready_out0, bus.ready_out1} !== 2'b10) $display("FAIL fair_first: got r0r1=%b expected 10", {bus.ready_out0, bus.ready_out1});
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      int k = i / 4;
      logic [31:0] w;
      logic e0, e1;
      w = fair_word(k % 2, k / 2);
      e0 = (i % 4 == 3) && (i < 12) && ((k + 1) % 2 == 0);
      e1 = (i % 4 == 3) && (i < 12) && ((k + 1) % 2 == 1);
      step();
      if (i == 12) begin
        bus.valid_in0 = 1'b0;
        bus.valid_in1 = 1'b0;
      end else if (i % 4 == 0) begin
        if (k % 2 == 0) begin j0++; bus.Data_in0 = fair_word(0, j0); end
        else begin j1++; bus.Data_in1 = fair_word(1, j1); end
      end
      @(negedge clk_4f);
      n_total++;
      if ({bus.valid_out, bus.src_out, bus.Data_out, bus.ready_out0, bus.ready_out1} !== {1'b1, k[0], byte_of(w, i % 4), e0, e1})
        $display("FAIL fair_cycle%0d: got v=%b s=%b d=%h r0=%b r1=%b expected v=1 s=%b d=%h r0=%b r1=%b",
                 i, bus.valid_out, bus.src_out, bus.Data_out, bus.ready_out0, bus.ready_out1, k[0], byte_of(w, i % 4), e0, e1);
      else n_pass++;
    end
    step();
    @(negedge clk_4f);
    n_total++;
    if ({bus.valid_out, bus.busy} !== 2'b00) $display("FAIL fair_end: got v=%b b=%b expected 0 0", bus.valid_out, bus.busy);
    else n_pass++;
  endtask

  task automatic send_req1(input logic [31:0] w, input string tag);
    step();
    bus.valid_in1 = 1'b1;
    bus.Data_in1  = w;
    @(negedge clk_4f);
    n_total++;
    if ({bus.ready_out1, bus.valid_out} !== 2'b10) $display("FAIL %s_accept: got r1=%b v=%b expected 1 0", tag, bus.ready_out1, bus.valid_out);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) bus.valid_in1 = 1'b0;
      @(negedge clk_4f);
      n_total++;
      if ({bus.valid_out, bus.src_out, bus.Data_out} !== {2'b11, byte_of(w, i)})
        $display("FAIL %s_byte%0d: got v=%b s=%b d=%h expected v=1 s=1 d=%h", tag, i, bus.valid_out, bus.src_out, bus.Data_out, byte_of(w, i));
      else n_pass++;
    end
  endtask

  task automatic test_gap();
    send_req1(32'hAABBCCDD, "gap_w1");
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk_4f);
      n_total++;
      if ({bus.valid_out, bus.Data_out, bus.busy, bus.src_out} !== {1'b0, 8'h00, 1'b0, 1'b1})
        $display("FAIL gap_idle%0d: got v=%b d=%h b=%b s=%b expected 0 00 0 1", i, bus.valid_out, bus.Data_out, bus.busy, bus.src_out);
      else n_pass++;
    end
    send_req1(32'h11223344, "gap_w2");
  endtask

  task automatic test_reset_mid_word();
    step();
    bus.valid_in0 = 1'b1;
    bus.Data_in0  = 32'hFFAAFFBB;
    @(negedge clk_4f);
    step();
    bus.valid_in0 = 1'b0;
    @(negedge clk_4f);
    n_total++;
    if (bus.Data_out !== 8'hFF) $display("FAIL rst_mid_b0: got %h expected ff", bus.Data_out);
    else n_pass++;
    step();
    @(negedge clk_4f);
    n_total++;
    if (bus.Data_out !== 8'hAA) $display("FAIL rst_mid_b1: got %h expected aa", bus.Data_out);
    else n_pass++;
    step();
    reset = 1'b0;
    bus.valid_in0 = 1'b1;
    bus.Data_in0  = 32'hDEADBEEF;
    @(negedge clk_4f);
    n_total++;
    if (bus.ready_out0 !== 1'b0) $display("FAIL rst_mid_ready_gate: got %b expected 0", bus.ready_out0);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) bus.valid_in0 = 1'b0;
      @(negedge clk_4f);
      n_total++;
      if ({bus.valid_out, bus.Data_out, bus.busy, bus.src_out} !== 11'h000)
        $display("FAIL rst_mid_quiet%0d: got v=%b d=%h b=%b s=%b expected all zero", i, bus.valid_out, bus.Data_out, bus.busy, bus.src_out);
      else n_pass++;
    end
    reset = 1'b1;
    test_tie(32'h12345678, 32'h9ABCDEF0, "rst_tie");
  endtask

  task automatic test_no_accept_hold();
    logic [31:0] w0 = 32'hC0FFEE11;
    step();
    bus.valid_in1 = 1'b1;
    bus.Data_in1  = 32'h55667788;
    @(negedge clk_4f);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] eb;
      eb = (i < 4) ? byte_of(32'h55667788, i) : byte_of(w0, i - 4);
      step();
      if (i == 0) begin
        bus.valid_in1 = 1'b0;
        bus.valid_in0 = 1'b1;
        bus.Data_in0  = w0;
      end
      if (i == 4) bus.valid_in0 = 1'b0;
      @(negedge clk_4f);
      n_total++;
      if ({bus.valid_out, bus.src_out, bus.Data_out, bus.ready_out0} !== {1'b1, (i < 4), eb, (i == 3)})
        $display("FAIL hold_cycle%0d: got v=%b s=%b d=%h r0=%b expected v=1 s=%b d=%h r0=%b",
                 i, bus.valid_out, bus.src_out, bus.Data_out, bus.ready_out0, (i < 4), eb, (i == 3));
      else n_pass++;
    end
    step();
    @(negedge clk_4f);
    n_total++;
    if ({bus.valid_out, bus.Data_out} !== 9'h000) $display("FAIL hold_end: got v=%b d=%h expected 0 00", bus.valid_out, bus.Data_out);
    else n_pass++;
  endtask

  initial begin
    bus.valid_in0 = 1'b0;
    bus.valid_in1 = 1'b0;
    bus.Data_in0  = 32'h0;
    bus.Data_in1  = 32'h0;
    test_reset();
    test_single();
    apply_reset();
    test_tie(32'hDDCCDDEE, 32'h010F0A03, "tie");
    test_fairness();
    test_gap();
    test_reset_mid_word();
    test_no_accept_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
